// File: rtl/ctl_pause_arbiter.sv
// Pause arbiter: debounced local switches, game requests and the remote link merged into one registered pause.
// Optional define CTL_PAUSE_CAUSE_EN adds pause_cause, the request vector captured on entry to pause.
module ctl_pause_arbiter #(
  parameter int              N_SW          = 2,
  parameter int              N_GAME        = 1,
  parameter int              DB_CYCLES     = 65536,
  parameter logic [N_SW-1:0] MODE_TOGGLE   = '0,
  parameter int              RESUME_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SW-1:0]   sw_pause_raw,
  input  logic [N_GAME-1:0] game_pause,
  input  logic              player2_pause,
  output logic              player1_pause,
  output logic              pause,
  output logic              resuming
`ifdef CTL_PAUSE_CAUSE_EN
  ,
  output logic [N_SW+N_GAME:0] pause_cause
`endif
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int RCW = (RESUME_CYCLES > 1) ? $clog2(RESUME_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_PAUSED   = 2'd1,
    ST_RESUMING = 2'd2
  } state_t;

  logic [N_SW-1:0] sync1, sync2, db, lat;
  logic [N_SW-1:0] db_nxt, lat_nxt;
  logic [DBW-1:0]  db_cnt     [N_SW];
  logic [DBW-1:0]  db_cnt_nxt [N_SW];
  logic            rq;

  state_t          state_q, state_d;
  logic [RCW-1:0]  cnt_q, cnt_d;
  logic [N_SW+N_GAME:0] req_vec;
  logic            req;

  // Debounce and latch next-state for every switch channel.
  always_comb begin
    db_nxt  = db;
    lat_nxt = lat;
    for (int i = 0; i < N_SW; i++) begin
      db_cnt_nxt[i] = '0;
      if (sync2[i] != db[i]) begin
        if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
          db_nxt[i] = sync2[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + 1'b1;
        end
      end
      if (MODE_TOGGLE[i]) begin
        if (db_nxt[i] && !db[i]) begin
          lat_nxt[i] = ~lat[i];
        end
      end else begin
        lat_nxt[i] = db_nxt[i];
      end
    end
  end

  // player1_pause is taken from lat_nxt so it is the registered copy of |lat.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      db            <= '0;
      lat           <= '0;
      rq            <= 1'b0;
      player1_pause <= 1'b0;
      for (int i = 0; i < N_SW; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1         <= sw_pause_raw;
      sync2         <= sync1;
      db            <= db_nxt;
      lat           <= lat_nxt;
      rq            <= player2_pause;
      player1_pause <= |lat_nxt;
      for (int i = 0; i < N_SW; i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
      end
    end
  end

  assign req_vec = {rq, game_pause, lat};
  assign req     = |req_vec;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (req) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (!req) begin
          if (RESUME_CYCLES == 0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RESUMING;
            cnt_d   = RCW'((RESUME_CYCLES > 0) ? RESUME_CYCLES - 1 : 0);
          end
        end
      end
      ST_RESUMING: begin
        if (req) begin
          state_d = ST_PAUSED;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are registered from state_d so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      pause    <= 1'b0;
      resuming <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pause    <= (state_d != ST_RUN);
      resuming <= (state_d == ST_RESUMING);
    end
  end

`ifdef CTL_PAUSE_CAUSE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pause_cause <= '0;
    end else if (state_q == ST_RUN && state_d == ST_PAUSED) begin
      pause_cause <= req_vec;
    end
  end
`endif

endmodule
